wrr_arb: RTL

WRR_ARB -- requirements
Module: wrr_arb

---
 rtl/wrr_arb_pkg.sv | 9 +
 rtl/wrr_arb_if.sv | 14 +
 rtl/lzc.sv | 26 ++
 rtl/wrr_arb.sv | 130 +++++++++++++
 4 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
package wrr_arb_pkg;

    // Index width for an N-input selector; a single input still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arb_if.sv
// Downstream request channel of the arbiter: the selected request, its
// payload and index travel out, the grant comes back.
interface wrr_arb_if #(
    parameter int DataWidth = 32,
    parameter int IdxWidth  = 2
) ();
    logic                 req;
    logic                 gnt;
    logic [DataWidth-1:0] data;
    logic [IdxWidth-1:0]  idx;

    modport master (output req, output data, output idx, input gnt);
    modport slave  (input req, input data, input idx, output gnt);
endinterface

// File: rtl/lzc.sv
// Zero counter scanning upward from bit 0: reports the position of the lowest
// set bit, or 0 with empty_o raised when no bit is set.
module lzc
    import wrr_arb_pkg::*;
#(
    parameter int Width    = 4,
    parameter int CntWidth = idxWidth(Width)
) (
    input  logic [Width-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = Width - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o   = CntWidth'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: each input may win up to weight_i consecutive
// handshakes before the turn passes to the next requester. With LockIn set, a
// stalled selection is held until the downstream accepts it.
module wrr_arb
    import wrr_arb_pkg::*;
#(
    parameter int NumIn       = 4,
    parameter int DataWidth   = 32,
    parameter int WeightWidth = 4,
    parameter int LockIn      = 1,
    localparam int IdxWidth   = idxWidth(NumIn)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NumIn-1:0][WeightWidth-1:0]    weight_i,
    input  logic [NumIn-1:0]                     req_i,
    output logic [NumIn-1:0]                     gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]      data_i,
    wrr_arb_if.master                            dn
);

    if (NumIn == 1) begin : gSingle
        assign dn.req  = req_i[0];
        assign dn.idx  = '0;
        assign dn.data = data_i[0];
        assign gnt_o   = dn.gnt & req_i[0];
    end else begin : gMulti
        localparam int CW = WeightWidth + 1;

        logic [IdxWidth-1:0]    ptr_q, ptr_d, lidx_q, lidx_d;
        logic [WeightWidth-1:0] cnt_q, cnt_d;
        logic                   lock_q, lock_d;
        logic [NumIn-1:0]       maskedReq;
        logic [IdxWidth-1:0]    maskedIdx, wrapIdx, searchIdx, sel, nextPtr;
        logic                   maskedEmpty, wrapEmpty;
        logic                   reqAny, gntIn, handshake;
        logic [WeightWidth-1:0] weightEff;
        logic [CW-1:0]          cntInc;
        logic [DataWidth-1:0]   dataSel;

        // Keep only requesters at or above the pointer for the first search.
        always_comb begin
            maskedReq = '0;
            for (int i = 0; i < NumIn; i++) begin
                maskedReq[i] = req_i[i] && (i >= int'(ptr_q));
            end
        end

        lzc #(.Width(NumIn), .CntWidth(IdxWidth)) uMasked (
            .in_i    (maskedReq),
            .cnt_o   (maskedIdx),
            .empty_o (maskedEmpty)
        );

        lzc #(.Width(NumIn), .CntWidth(IdxWidth)) uWrap (
            .in_i    (req_i),
            .cnt_o   (wrapIdx),
            .empty_o (wrapEmpty)
        );

        assign searchIdx = wrapEmpty ? '0 : (maskedEmpty ? wrapIdx : maskedIdx);
        assign sel       = lock_q ? lidx_q : searchIdx;
        assign reqAny    = |req_i;
        assign gntIn     = dn.gnt;
        assign handshake = reqAny & gntIn;
        assign dataSel   = data_i[sel];

        assign dn.req  = reqAny;
        assign dn.idx  = sel;
        assign dn.data = dataSel;

        // Route the downstream grant back to the selected input only.
        always_comb begin
            gnt_o      = '0;
            gnt_o[sel] = handshake;
        end

        // Zero weight behaves as one; explicit wrap keeps odd NumIn in range.
        assign weightEff = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];
        assign cntInc    = (sel == ptr_q) ? ({1'b0, cnt_q} + CW'(1)) : CW'(1);
        assign nextPtr   = (int'(sel) == NumIn - 1) ? '0 : sel + IdxWidth'(1);

        // Next-state: flush beats the handshake and lock updates.
        always_comb begin
            ptr_d  = ptr_q;
            cnt_d  = cnt_q;
            lock_d = lock_q;
            lidx_d = lidx_q;
            if (flush_i) begin
                ptr_d  = '0;
                cnt_d  = '0;
                lock_d = 1'b0;
            end else if (handshake) begin
                lock_d = 1'b0;
                if (cntInc >= {1'b0, weightEff}) begin
                    ptr_d = nextPtr;
                    cnt_d = '0;
                end else begin
                    ptr_d = sel;
                    cnt_d = cntInc[WeightWidth-1:0];
                end
            end else if ((LockIn != 0) && reqAny) begin
                lock_d = 1'b1;
                lidx_d = sel;
            end
        end

        // Pointer, credit and lock registers; reset discards everything.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_q  <= '0;
                cnt_q  <= '0;
                lock_q <= 1'b0;
                lidx_q <= '0;
            end else begin
                ptr_q  <= ptr_d;
                cnt_q  <= cnt_d;
                lock_q <= lock_d;
                lidx_q <= lidx_d;
            end
        end

        // A locked input must keep requesting with the payload it stalled on.
        lockHold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            ((LockIn != 0) && reqAny && !gntIn && !flush_i) |=>
            (!lock_q || (req_i[lidx_q] && (data_i[lidx_q] == $past(dataSel)))));
    end

endmodule
